i2s_capture_controller: RTL and testbench
=========================================

Name: i2s_capture_controller

Overview:
Master-mode sequencer for the I2S receive path. Generates SCK and WS from the system clock, captures the serial data bits into PCM words, and reports one word per channel slot. It also owns the write pointer of the circular sample buffer. Read requests for delayed taps are resolved into buffer addresses through a one-cycle request/acknowledge handshake.

Parameters:
NUMBER_OF_BITS, 8, PCM word width captured per slot (MSB first)
SLOT_BITS, 16, SCK periods per WS half-frame; must be >= NUMBER_OF_BITS+1
BIT_DIV, 4, clk cycles per SCK period; even, >= 2
BUFFER_DEPTH, 10, sample-buffer entries; 2 <= BUFFER_DEPTH <= 2^ADDR_WIDTH
ADDR_WIDTH, 4, buffer address / delay width

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  run request; sampled every cycle
data_in  in  1  I2S serial data from microphone/codec
sck  out  1  generated bit clock (registered)
ws  out  1  generated word select (registered); 0 = left, 1 = right
sample_valid  out  1  one-cycle pulse: new word on sample_data
sample_channel  out  1  channel of the current word (ws value during its slot)
sample_data  out  NUMBER_OF_BITS  captured word; held until the next sample_valid
buf_wr_en  out  1  buffer write strobe; equal to sample_valid
buf_wr_addr  out  ADDR_WIDTH  write address for the current word
rd_req  in  1  delayed-tap address request
rd_delay  in  ADDR_WIDTH  taps back from the newest word (0 = newest)
rd_ack  out  1  one-cycle pulse, one cycle after rd_req
rd_addr  out  ADDR_WIDTH  resolved address; valid with rd_ack
rd_err  out  1  valid with rd_ack; requested tap not yet written
busy  out  1  high when the FSM state is not IDLE

Behaviour:
- Reset: state IDLE. sck=0, ws=0, sample_valid=0, sample_channel=0, sample_data=0, buf_wr_en=0, buf_wr_addr=0, rd_ack=0, rd_addr=0, rd_err=0, busy=0. Internal wr_ptr=0, fill=0, div_cnt=0, bit_cnt=0, shift register=0.
- FSM states:
  - IDLE -> RUN when enable=1. The first RUN cycle has div_cnt=0, bit_cnt=0, ws=0.
  - RUN -> STOPPING when enable=0.
  - STOPPING -> RUN when enable=1 again before the frame boundary.
  - STOPPING -> IDLE at the end of the last SCK period of the right slot (frame boundary). sck and ws return to 0 and the counters clear.
- In IDLE: sck=0, ws=0, no captures.
- SCK generation (RUN/STOPPING): div_cnt counts 0..BIT_DIV-1 and wraps. sck=0 while div_cnt < BIT_DIV/2, else 1. Registered, so sck rises on the edge where div_cnt becomes BIT_DIV/2.
- Capture: data_in is sampled on the clk edge at which sck goes 0->1.
- Slot structure: bit_cnt counts 0..SLOT_BITS-1 and advances on each SCK falling transition.
  - ws toggles on the SCK falling transition where bit_cnt wraps from SLOT_BITS-1 to 0.
  - Slot bit 0 is the I2S delay bit; it is ignored.
  - Bits 1..NUMBER_OF_BITS are shifted in MSB first.
  - Bits above NUMBER_OF_BITS are ignored.
- Word output: on the clk edge after the rising-edge capture of slot bit NUMBER_OF_BITS:
  - sample_data is loaded and sample_valid=1 for one cycle.
  - sample_channel = ws, buf_wr_en=1, buf_wr_addr=wr_ptr.
  - On the following edge, wr_ptr increments, wrapping BUFFER_DEPTH-1 -> 0. fill increments and saturates at BUFFER_DEPTH.
- Latency: one word per slot, two words per frame. Frame period = 2*SLOT_BITS*BIT_DIV clk cycles.
- Read handshake: rd_req is sampled each cycle. One cycle later rd_ack=1 and:
  - rd_addr = (wr_ptr - 1 - rd_delay) mod BUFFER_DEPTH, computed without a power-of-two assumption.
  - wr_ptr is the value in the rd_req cycle, before any increment in that cycle. A simultaneous write is therefore not visible to that read.
  - rd_err = 1 if rd_delay >= fill, or if rd_delay >= BUFFER_DEPTH. rd_addr is still driven by the formula.
- Back-to-back rd_req on consecutive cycles gives consecutive rd_ack pulses; there is no stall.
- Reads are served in every state, including IDLE.
- Reset mid-frame: the partial word is discarded with no sample_valid. All registers return to their reset values on the next edge.
- enable dropped mid-slot: capture continues to the frame boundary, so the right word of the current frame is still produced.

Test Plan:
- BIT_DIV=4, SLOT_BITS=16, enable=1, data_in driven with 0xA5 (left) and 0x3C (right) after the delay bit -> sample_valid on the left word, sample_data=0xA5, sample_channel=0; then on the right word, sample_data=0x3C, sample_channel=1. Words are exactly 64 clk apart; ws period is 128 clk.
- Check SCK/WS timing -> sck high 2 clk and low 2 clk. ws toggles only on an sck falling transition after bit 15. Delay-bit value 1 does not corrupt the word.
- Run 12 words -> buf_wr_addr sequence 0..9,0,1. After the first wrap, fill stays at 10.
- After 3 words (wr_ptr=3, fill=3):
  - rd_delay=0 -> rd_addr=2, rd_err=0, one cycle after rd_req.
  - rd_delay=2 -> rd_addr=0.
  - rd_delay=3 -> rd_err=1.
  - After the wrap, with wr_ptr=1: rd_delay=4 -> rd_addr=6.
- rd_req in the same cycle as buf_wr_en at addr 5 -> rd_delay=0 returns rd_addr=4.
- Deassert enable at left bit 3 -> the left and right words both complete, then busy=0 and sck=ws=0 at the frame boundary. Assert reset mid-word -> no sample_valid, all outputs 0 next cycle.

Source files
------------

// File: rtl/i2s_capture_controller.sv
// I2S master receive sequencer: generates SCK/WS, deserialises one PCM word per slot,
// owns the sample-buffer write pointer and resolves delayed-tap read requests.
module i2s_capture_controller #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int SLOT_BITS      = 16,
  parameter int BIT_DIV        = 4,
  parameter int BUFFER_DEPTH   = 10,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      data_in,
  output logic                      sck,
  output logic                      ws,
  output logic                      sample_valid,
  output logic                      sample_channel,
  output logic [NUMBER_OF_BITS-1:0] sample_data,
  output logic                      buf_wr_en,
  output logic [ADDR_WIDTH-1:0]     buf_wr_addr,
  input  logic                      rd_req,
  input  logic [ADDR_WIDTH-1:0]     rd_delay,
  output logic                      rd_ack,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_err,
  output logic                      busy
);

  localparam int DIV_W  = $clog2(BIT_DIV);
  localparam int BIT_W  = $clog2(SLOT_BITS);
  localparam int FILL_W = ADDR_WIDTH + 1;
  localparam logic [DIV_W-1:0]      DIV_LAST     = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_HALF     = DIV_W'(BIT_DIV / 2);
  localparam logic [DIV_W-1:0]      DIV_PRE_RISE = DIV_W'(BIT_DIV / 2 - 1);
  localparam logic [BIT_W-1:0]      SLOT_LAST    = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]      WORD_LAST    = BIT_W'(NUMBER_OF_BITS);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST     = ADDR_WIDTH'(BUFFER_DEPTH - 1);
  localparam logic [FILL_W-1:0]     FILL_MAX     = FILL_W'(BUFFER_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic                      sck_q, sck_d, ws_q, ws_d;
  logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
  logic                      cap_last_q, cap_last_d;
  logic                      frame_end;

  logic                      valid_q, chan_q;
  logic [NUMBER_OF_BITS-1:0] data_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_ptr_q, rd_addr_q;
  logic [FILL_W-1:0]         fill_q;
  logic                      rd_ack_q, rd_err_q;

  // Modulo arithmetic done in integers so BUFFER_DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] tap_addr(input logic [ADDR_WIDTH-1:0] ptr,
                                                     input logic [ADDR_WIDTH-1:0] delay);
    int t;
    t = int'(ptr) + BUFFER_DEPTH - 1 - (int'(delay) % BUFFER_DEPTH);
    if (t >= BUFFER_DEPTH) t = t - BUFFER_DEPTH;
    return ADDR_WIDTH'(t);
  endfunction

  assign frame_end = (div_q == DIV_LAST) && (bit_q == SLOT_LAST) && ws_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: if (enable) state_d = RUN;
                else if (frame_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counters stay cleared in IDLE and on the edge that returns to IDLE.
  always_comb begin
    div_d      = '0;
    bit_d      = '0;
    sck_d      = 1'b0;
    ws_d       = 1'b0;
    shift_d    = shift_q;
    cap_last_d = 1'b0;
    if (state_q != IDLE && state_d != IDLE) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      sck_d = (div_d >= DIV_HALF);
      bit_d = bit_q;
      ws_d  = ws_q;
      if (div_q == DIV_LAST) begin
        bit_d = (bit_q == SLOT_LAST) ? '0 : bit_q + 1'b1;
        if (bit_q == SLOT_LAST) ws_d = ~ws_q;
      end
      if (div_q == DIV_PRE_RISE && bit_q != '0 && bit_q <= WORD_LAST) begin
        shift_d    = NUMBER_OF_BITS'({shift_q, data_in});
        cap_last_d = (bit_q == WORD_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      shift_q    <= '0;
      cap_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      shift_q    <= shift_d;
      cap_last_q <= cap_last_d;
    end
  end

  // Word publication, buffer write pointer and the read-tap handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      chan_q    <= 1'b0;
      data_q    <= '0;
      wr_addr_q <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      rd_ack_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      valid_q <= cap_last_q;
      if (cap_last_q) begin
        data_q    <= shift_q;
        chan_q    <= ws_q;
        wr_addr_q <= wr_ptr_q;
      end
      if (valid_q) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
      end
      rd_ack_q <= rd_req;
      if (rd_req) begin
        rd_addr_q <= tap_addr(wr_ptr_q, rd_delay);
        rd_err_q  <= ({1'b0, rd_delay} >= fill_q) || (int'(rd_delay) >= BUFFER_DEPTH);
      end
    end
  end

  assign sck            = sck_q;
  assign ws             = ws_q;
  assign sample_valid   = valid_q;
  assign sample_channel = chan_q;
  assign sample_data    = data_q;
  assign buf_wr_en      = valid_q;
  assign buf_wr_addr    = wr_addr_q;
  assign rd_ack         = rd_ack_q;
  assign rd_addr        = rd_addr_q;
  assign rd_err         = rd_err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_capture_controller.sv
// Bench for i2s_capture_controller: cycle-indexed I2S frame model plus a buffer-pointer
// model derived from the number of words completed before each read request.
module tb_i2s_capture_controller;
  localparam int NB        = 8;
  localparam int SB        = 16;
  localparam int BD        = 4;
  localparam int DEPTH     = 10;
  localparam int AW        = 4;
  localparam int SLOT_CYC  = SB * BD;
  localparam int VALID_OFS = NB * BD + BD / 2 + 1;

  logic          clk = 1'b0;
  logic          reset, enable, data_in, rd_req;
  logic [AW-1:0] rd_delay;
  logic          sck, ws, sample_valid, sample_channel, buf_wr_en, rd_ack, rd_err, busy;
  logic [NB-1:0] sample_data;
  logic [AW-1:0] buf_wr_addr, rd_addr;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc;
  bit   running;
  logic [7:0] words [0:15];

  i2s_capture_controller #(
    .NUMBER_OF_BITS(NB), .SLOT_BITS(SB), .BIT_DIV(BD),
    .BUFFER_DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .sck(sck), .ws(ws), .sample_valid(sample_valid), .sample_channel(sample_channel),
    .sample_data(sample_data), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .rd_req(rd_req), .rd_delay(rd_delay), .rd_ack(rd_ack), .rd_addr(rd_addr),
    .rd_err(rd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Serial line value during run-cycle c: delay bit forced to 1, noise above the word.
  function automatic logic model_bit(input int c);
    int s, b;
    logic [7:0] w;
    s = c / SLOT_CYC;
    b = (c / BD) % SB;
    if (b == 0) return 1'b1;
    if (b <= NB) begin
      w = words[s % 16];
      return w[NB - b];
    end
    return 1'($urandom_range(1));
  endfunction

  function automatic int words_before(input int c);
    return (c <= VALID_OFS) ? 0 : (c - VALID_OFS - 1) / SLOT_CYC + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (running) cyc++;
    data_in = running ? model_bit(cyc) : 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; rd_req = 1'b0; rd_delay = '0;
    running = 1'b0; data_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1; running = 1'b1; cyc = -1;
  endtask

  task automatic init_words(input logic [7:0] a, input logic [7:0] b);
    words[0] = a;
    words[1] = b;
    for (int i = 2; i < 16; i++) words[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rd_req = 1'b0; rd_delay = '0; running = 1'b0; data_in = 1'b0;
    tick(); tick();
    n_vec++; if (sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", sck); end
    n_vec++; if (ws !== 1'b0) begin n_bad++; $display("FAIL reset_ws: got %b want 0", ws); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    n_vec++;
    if ({sample_channel, sample_data, buf_wr_en, buf_wr_addr} !== '0) begin
      n_bad++; $display("FAIL reset_wordside: got ch=%b data=%h wen=%b waddr=%0d want all 0",
                        sample_channel, sample_data, buf_wr_en, buf_wr_addr);
    end
    n_vec++;
    if ({rd_ack, rd_addr, rd_err} !== '0) begin
      n_bad++; $display("FAIL reset_readside: got ack=%b addr=%0d err=%b want all 0", rd_ack, rd_addr, rd_err);
    end
    // A read in IDLE with an empty buffer: address wraps below zero and flags an error.
    reset = 1'b0; rd_req = 1'b1; rd_delay = 4'd0;
    tick();
    rd_req = 1'b0;
    n_vec++; if (rd_ack !== 1'b1) begin n_bad++; $display("FAIL idle_rd_ack: got %b want 1", rd_ack); end
    n_vec++; if (rd_addr !== 4'd9) begin n_bad++; $display("FAIL idle_rd_addr: got %0d want 9", rd_addr); end
    n_vec++; if (rd_err !== 1'b1) begin n_bad++; $display("FAIL idle_rd_err: got %b want 1", rd_err); end
    tick();
    n_vec++; if (rd_ack !== 1'b0) begin n_bad++; $display("FAIL idle_rd_ack_drop: got %b want 0", rd_ack); end
    n_vec++; if (sck !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_quiet: got sck=%b busy=%b want 0 0", sck, busy); end
  endtask

  task automatic test_stream();
    bit   e_sck, e_ws, e_valid, p_req, req, e_err;
    int   k, p_d, p_cnt, d, wp, fl, e_addr;
    do_reset();
    init_words(8'hA5, 8'h3C);
    start_run();
    p_req = 1'b0; p_d = 0; p_cnt = 0;
    for (int i = 0; i < 760; i++) begin
      tick();
      e_sck   = (cyc % BD) >= BD / 2;
      e_ws    = ((cyc / SLOT_CYC) % 2) == 1;
      e_valid = (cyc % SLOT_CYC) == VALID_OFS;
      n_vec++; if (sck !== e_sck) begin n_bad++; $display("FAIL stream_sck c=%0d: got %b want %b", cyc, sck, e_sck); end
      n_vec++; if (ws !== e_ws) begin n_bad++; $display("FAIL stream_ws c=%0d: got %b want %b", cyc, ws, e_ws); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stream_busy c=%0d: got %b want 1", cyc, busy); end
      n_vec++; if (sample_valid !== e_valid || buf_wr_en !== e_valid) begin
        n_bad++; $display("FAIL stream_valid c=%0d: got v=%b wen=%b want %b", cyc, sample_valid, buf_wr_en, e_valid);
      end
      if (cyc >= VALID_OFS) begin
        k = (cyc - VALID_OFS) / SLOT_CYC;
        n_vec++; if (sample_data !== words[k]) begin
          n_bad++; $display("FAIL stream_data c=%0d: got %h want %h", cyc, sample_data, words[k]);
        end
        if (e_valid) begin
          n_vec++; if (sample_channel !== 1'(k % 2)) begin
            n_bad++; $display("FAIL stream_chan c=%0d: got %b want %0d", cyc, sample_channel, k % 2);
          end
          n_vec++; if (buf_wr_addr !== AW'(k % DEPTH)) begin
            n_bad++; $display("FAIL stream_waddr c=%0d: got %0d want %0d", cyc, buf_wr_addr, k % DEPTH);
          end
        end
      end
      n_vec++; if (rd_ack !== p_req) begin n_bad++; $display("FAIL stream_rd_ack c=%0d: got %b want %b", cyc, rd_ack, p_req); end
      if (p_req) begin
        wp     = p_cnt % DEPTH;
        fl     = (p_cnt < DEPTH) ? p_cnt : DEPTH;
        e_addr = ((wp - 1 - p_d) % DEPTH + DEPTH) % DEPTH;
        e_err  = (p_d >= fl) || (p_d >= DEPTH);
        n_vec++; if (rd_addr !== AW'(e_addr)) begin
          n_bad++; $display("FAIL stream_rd_addr c=%0d d=%0d: got %0d want %0d", cyc, p_d, rd_addr, e_addr);
        end
        n_vec++; if (rd_err !== e_err) begin
          n_bad++; $display("FAIL stream_rd_err c=%0d d=%0d: got %b want %b", cyc, p_d, rd_err, e_err);
        end
      end
      case (cyc)
        180: begin req = 1'b1; d = 0;  end
        181: begin req = 1'b1; d = 2;  end
        182: begin req = 1'b1; d = 3;  end
        355: begin req = 1'b1; d = 0;  end
        700: begin req = 1'b1; d = 4;  end
        720: begin req = 1'b1; d = 9;  end
        721: begin req = 1'b1; d = 10; end
        default: begin req = ($urandom_range(3) == 0); d = int'($urandom_range(15)); end
      endcase
      rd_req = req; rd_delay = AW'(d);
      p_req = req; p_d = d; p_cnt = words_before(cyc);
    end
    rd_req = 1'b0; enable = 1'b0;
  endtask

  task automatic test_stop();
    bit e_on, e_sck, e_ws, e_valid;
    do_reset();
    init_words(8'($urandom), 8'($urandom));
    start_run();
    for (int i = 0; i < 150; i++) begin
      tick();
      e_on    = cyc < 2 * SLOT_CYC;
      e_sck   = e_on && ((cyc % BD) >= BD / 2);
      e_ws    = e_on && (((cyc / SLOT_CYC) % 2) == 1);
      e_valid = e_on && ((cyc % SLOT_CYC) == VALID_OFS);
      n_vec++; if (busy !== e_on) begin n_bad++; $display("FAIL stop_busy c=%0d: got %b want %b", cyc, busy, e_on); end
      n_vec++; if (sck !== e_sck || ws !== e_ws) begin
        n_bad++; $display("FAIL stop_clocks c=%0d: got sck=%b ws=%b want %b %b", cyc, sck, ws, e_sck, e_ws);
      end
      n_vec++; if (sample_valid !== e_valid) begin
        n_bad++; $display("FAIL stop_valid c=%0d: got %b want %b", cyc, sample_valid, e_valid);
      end
      if (e_valid) begin
        n_vec++; if (sample_data !== words[cyc / SLOT_CYC] || sample_channel !== 1'((cyc / SLOT_CYC) % 2)) begin
          n_bad++; $display("FAIL stop_word c=%0d: got %h/%b want %h/%0d", cyc, sample_data, sample_channel,
                            words[cyc / SLOT_CYC], (cyc / SLOT_CYC) % 2);
        end
      end
      if (cyc == 3 * BD) enable = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    init_words(8'($urandom) | 8'h01, 8'($urandom));
    start_run();
    for (int i = 0; i < SLOT_CYC + VALID_OFS - 1 + 1; i++) tick();
    n_vec++; if (sample_data !== words[0]) begin
      n_bad++; $display("FAIL mid_pre_data c=%0d: got %h want %h", cyc, sample_data, words[0]);
    end
    reset = 1'b1; enable = 1'b0; running = 1'b0;
    tick();
    n_vec++; if (sample_valid !== 1'b0 || buf_wr_en !== 1'b0) begin
      n_bad++; $display("FAIL mid_no_valid: got v=%b wen=%b want 0 0", sample_valid, buf_wr_en);
    end
    n_vec++; if ({sck, ws, busy, sample_channel, sample_data, buf_wr_addr, rd_ack, rd_addr, rd_err} !== '0) begin
      n_bad++; $display("FAIL mid_outputs: got sck=%b ws=%b busy=%b ch=%b data=%h waddr=%0d want all 0",
                        sck, ws, busy, sample_channel, sample_data, buf_wr_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      n_vec++; if (sample_valid !== 1'b0 || sck !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL mid_after i=%0d: got v=%b sck=%b busy=%b want 0 0 0", i, sample_valid, sck, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
